// File: rtl/video_bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit video bus-master port among NUM_REQ requesters.
// Optional bus-wait timeout: define VIDEO_BUS_ARB_TIMEOUT_EN.
module video_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rnw,
    input  logic [NUM_REQ*30-1:0] req_address,
    input  logic [NUM_REQ*8-1:0] req_write_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           req_read_data,
    output logic [29:0]          bus_address,
    output logic                 bus_byte_enable,
    output logic                 bus_read,
    output logic                 bus_write,
    output logic [7:0]           bus_write_data,
    input  logic                 bus_acknowledge,
    input  logic [7:0]           bus_read_data,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_grant;
    logic [2:0]           w_grant_nxt;
    logic [29:0]          r_addr;
    logic [29:0]          w_addr_nxt;
    logic [7:0]           r_wdata;
    logic [7:0]           w_wdata_nxt;
    logic                 r_rnw;
    logic                 w_rnw_nxt;
    logic [7:0]           r_rdata;
    logic [7:0]           w_rdata_nxt;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic                 r_bus_rd;
    logic                 r_bus_wr;
    logic                 r_bus_be;
    logic                 r_busy;

    logic                 w_found;
    int                   w_j;
    logic [IW-1:0]        w_idx;
    logic [2:0]           w_winner;
    logic [29:0]          w_addr_sel;
    logic [7:0]           w_wdata_sel;
    logic                 w_rnw_sel;

`ifdef VIDEO_BUS_ARB_TIMEOUT_EN
    logic [15:0]          r_cnt;
    logic [15:0]          w_cnt_nxt;
    logic                 r_tout;
    logic                 w_tout_nxt;
`endif

    // Pick the first pending requester after the last grant, wrapping around.
    always_comb begin
        w_found     = 1'b0;
        w_j         = 0;
        w_idx       = '0;
        w_winner    = r_grant;
        w_addr_sel  = '0;
        w_wdata_sel = '0;
        w_rnw_sel   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_j   = (int'(r_grant) + i) % NUM_REQ;
            w_idx = w_j[IW-1:0];
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = 3'(w_j);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_addr_sel  = req_address[i*30 +: 30];
                w_wdata_sel = req_write_data[i*8 +: 8];
                w_rnw_sel   = req_rnw[i];
            end
        end
    end

    // Next-state and next-output logic for the IDLE/BUS/RESP sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rnw_nxt   = r_rnw;
        w_rdata_nxt = r_rdata;
        w_ack_nxt   = '0;
`ifdef VIDEO_BUS_ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_tout_nxt  = r_tout;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BUS;
                    w_grant_nxt = w_winner;
                    w_addr_nxt  = w_addr_sel;
                    w_wdata_nxt = w_wdata_sel;
                    w_rnw_nxt   = w_rnw_sel;
`ifdef VIDEO_BUS_ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            BUS: begin
                if (bus_acknowledge) begin
                    w_state_nxt = RESP;
                    w_ack_nxt   = NUM_REQ'(1) << r_grant;
                    if (r_rnw) begin
                        w_rdata_nxt = bus_read_data;
                    end
`ifdef VIDEO_BUS_ARB_TIMEOUT_EN
                end else if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = RESP;
                    w_ack_nxt   = NUM_REQ'(1) << r_grant;
                    w_rdata_nxt = 8'hFF;
                    w_tout_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
`endif
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered datapath and bus strobes, derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant  <= 3'(NUM_REQ - 1);
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rnw    <= 1'b0;
            r_rdata  <= '0;
            r_ack    <= '0;
            r_bus_rd <= 1'b0;
            r_bus_wr <= 1'b0;
            r_bus_be <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_grant  <= w_grant_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_rnw    <= w_rnw_nxt;
            r_rdata  <= w_rdata_nxt;
            r_ack    <= w_ack_nxt;
            r_bus_rd <= (w_state_nxt == BUS) && w_rnw_nxt;
            r_bus_wr <= (w_state_nxt == BUS) && !w_rnw_nxt;
            r_bus_be <= (w_state_nxt == BUS);
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

`ifdef VIDEO_BUS_ARB_TIMEOUT_EN
    // Bus-wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tout <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tout <= w_tout_nxt;
        end
    end

    assign timeout_err = r_tout;
`else
    // No timeout hardware: flag is tied low.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    assign req_ack         = r_ack;
    assign req_read_data   = r_rdata;
    assign bus_address     = r_addr;
    assign bus_write_data  = r_wdata;
    assign bus_read        = r_bus_rd;
    assign bus_write       = r_bus_wr;
    assign bus_byte_enable = r_bus_be;
    assign busy            = r_busy;
    assign grant_id        = r_grant;

endmodule

// File: tb/tb_video_bus_arbiter.sv
// Directed testbench for video_bus_arbiter.
// Build with VIDEO_BUS_ARB_TIMEOUT_EN to exercise the timeout path.
module tb_video_bus_arbiter;

    localparam int N = 4;
`ifdef VIDEO_BUS_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_rnw = '0;
    logic [N*30-1:0] req_address = '0;
    logic [N*8-1:0]  req_write_data = '0;
    logic [N-1:0]    req_ack;
    logic [7:0]      req_read_data;
    logic [29:0]     bus_address;
    logic            bus_byte_enable;
    logic            bus_read;
    logic            bus_write;
    logic [7:0]      bus_write_data;
    logic            bus_acknowledge = 1'b0;
    logic [7:0]      bus_read_data = '0;
    logic            busy;
    logic [2:0]      grant_id;
    logic            timeout_err;

    int errors = 0;
    int checks = 0;

    logic resp_en = 1'b0;
    int   ack_delay = 0;
    int   wcnt = 0;

    video_bus_arbiter #(
        .NUM_REQ(N),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_rnw(req_rnw),
        .req_address(req_address),
        .req_write_data(req_write_data),
        .req_ack(req_ack),
        .req_read_data(req_read_data),
        .bus_address(bus_address),
        .bus_byte_enable(bus_byte_enable),
        .bus_read(bus_read),
        .bus_write(bus_write),
        .bus_write_data(bus_write_data),
        .bus_acknowledge(bus_acknowledge),
        .bus_read_data(bus_read_data),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Interconnect model: ack after ack_delay strobe cycles.
    always @(negedge clk) begin
        if (resp_en && (bus_read || bus_write)) begin
            bus_acknowledge <= (wcnt == ack_delay);
            wcnt <= wcnt + 1;
        end else begin
            bus_acknowledge <= 1'b0;
            wcnt <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic rnw,
                           input logic [29:0] a, input logic [7:0] d);
        req_rnw[i] = rnw;
        req_address[i*30 +: 30] = a;
        req_write_data[i*8 +: 8] = d;
    endtask

    task automatic wait_ack(input int limit, output int cyc,
                            output int bcyc, output logic clash);
        cyc = 0;
        bcyc = 0;
        clash = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            cyc++;
            if (bus_read && bus_write) clash = 1'b1;
            if (bus_read || bus_write) bcyc++;
            if (req_ack != '0) return;
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        checks++;
        if (req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ack got=%b exp=0000", req_ack);
        end
        checks++;
        if ({bus_read, bus_write, bus_byte_enable, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {bus_read, bus_write, bus_byte_enable, busy});
        end
        checks++;
        if (grant_id !== 3'd3) begin
            errors++;
            $display("FAIL reset_grant got=%0d exp=3", grant_id);
        end
        checks++;
        if (bus_address !== 30'h0 || bus_write_data !== 8'h00 ||
            req_read_data !== 8'h00 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h/%h/%b exp=0/0/0/0",
                     bus_address, bus_write_data, req_read_data, timeout_err);
        end
    endtask

    task automatic test_single_write();
        int nw = 0;
        int bad = 0;
        logic got = 1'b0;
        logic [N-1:0] ack = '0;
        logic bsy = 1'b0;
        set_req(0, 1'b0, 30'h0800_0010, 8'h3C);
        ack_delay = 2;
        resp_en = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (bus_write) begin
                nw++;
                if (bus_address !== 30'h0800_0010 || bus_write_data !== 8'h3C ||
                    bus_byte_enable !== 1'b1 || bus_read !== 1'b0) bad++;
            end
            if (req_ack !== 4'b0000) begin
                got = 1'b1;
                ack = req_ack;
                bsy = busy;
                req_valid = '0;
            end
        end
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("FAIL write_ack got=%b exp=0001", ack);
        end
        checks++;
        if (nw !== 3) begin
            errors++;
            $display("FAIL write_strobe_len got=%0d exp=3", nw);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL write_bus_values got=%0d bad cycles exp=0", bad);
        end
        checks++;
        if (bsy !== 1'b1 || grant_id !== 3'd0) begin
            errors++;
            $display("FAIL write_resp got busy=%b grant=%0d exp busy=1 grant=0",
                     bsy, grant_id);
        end
        tick();
        checks++;
        if (req_ack !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_after got ack=%b busy=%b exp ack=0000 busy=0",
                     req_ack, busy);
        end
    endtask

    task automatic test_read();
        int cyc;
        int bcyc;
        logic clash;
        set_req(2, 1'b1, 30'h0000_0100, 8'h00);
        bus_read_data = 8'hA5;
        ack_delay = 5;
        resp_en = 1'b1;
        req_valid = 4'b0100;
        wait_ack(40, cyc, bcyc, clash);
        checks++;
        if (req_ack !== 4'b0100) begin
            errors++;
            $display("FAIL read_ack got=%b exp=0100", req_ack);
        end
        checks++;
        if (req_read_data !== 8'hA5) begin
            errors++;
            $display("FAIL read_data got=%h exp=a5", req_read_data);
        end
        checks++;
        if (bcyc !== 6 || clash !== 1'b0) begin
            errors++;
            $display("FAIL read_strobe_len got=%0d clash=%b exp=6 clash=0",
                     bcyc, clash);
        end
        checks++;
        if (grant_id !== 3'd2) begin
            errors++;
            $display("FAIL read_grant got=%0d exp=2", grant_id);
        end
        req_valid = '0;
        req_rnw = '0;
        tick();
    endtask

    task automatic test_fairness();
        int cyc;
        int bcyc;
        logic clash;
        logic [N-1:0] exp;
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 30'(i * 4), 8'(i));
        ack_delay = 0;
        resp_en = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_ack(20, cyc, bcyc, clash);
            exp = 4'b0001 << (k % 4);
            checks++;
            if (req_ack !== exp) begin
                errors++;
                $display("FAIL fair_order[%0d] got=%b exp=%b", k, req_ack, exp);
            end
            if (k > 0) begin
                checks++;
                if (cyc !== 3) begin
                    errors++;
                    $display("FAIL fair_period[%0d] got=%0d exp=3", k, cyc);
                end
            end
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_sparse();
        int cyc;
        int bcyc;
        logic clash;
        req_valid = 4'b0010;
        wait_ack(20, cyc, bcyc, clash);
        checks++;
        if (req_ack !== 4'b0010) begin
            errors++;
            $display("FAIL sparse_first got=%b exp=0010", req_ack);
        end
        req_valid = 4'b1001;
        wait_ack(20, cyc, bcyc, clash);
        checks++;
        if (req_ack !== 4'b1000) begin
            errors++;
            $display("FAIL sparse_second got=%b exp=1000", req_ack);
        end
        req_valid = 4'b0001;
        wait_ack(20, cyc, bcyc, clash);
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL sparse_third got=%b exp=0001", req_ack);
        end
        req_valid = '0;
        tick();
    endtask

`ifdef VIDEO_BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        int bcyc;
        logic clash;
        resp_en = 1'b0;
        set_req(1, 1'b1, 30'h0000_0200, 8'h00);
        req_valid = 4'b0010;
        wait_ack(60, cyc, bcyc, clash);
        checks++;
        if (req_ack !== 4'b0010) begin
            errors++;
            $display("FAIL tmo_ack got=%b exp=0010", req_ack);
        end
        checks++;
        if (bcyc !== 16) begin
            errors++;
            $display("FAIL tmo_bus_cycles got=%0d exp=16", bcyc);
        end
        checks++;
        if (req_read_data !== 8'hFF || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_data got=%h err=%b exp=ff err=1",
                     req_read_data, timeout_err);
        end
        req_valid = '0;
        repeat (5) tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky got=%b exp=1", timeout_err);
        end
    endtask
`else
    task automatic test_no_timeout();
        int cyc;
        int bcyc;
        logic clash;
        resp_en = 1'b0;
        set_req(1, 1'b1, 30'h0000_0200, 8'h00);
        req_valid = 4'b0010;
        wait_ack(40, cyc, bcyc, clash);
        checks++;
        if (cyc !== -1) begin
            errors++;
            $display("FAIL hang_no_ack got=%0d exp=-1", cyc);
        end
        checks++;
        if (bus_read !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL hang_state got rd=%b busy=%b err=%b exp 1/1/0",
                     bus_read, busy, timeout_err);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int cyc;
        int bcyc;
        logic clash;
        resp_en = 1'b0;
        set_req(1, 1'b1, 30'h0000_0300, 8'h00);
        req_valid = 4'b0010;
        repeat (4) tick();
        checks++;
        if (bus_read !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got=%b exp=1", bus_read);
        end
        reset = 1'b1;
        req_valid = '0;
        tick();
        checks++;
        if ({bus_read, bus_write, bus_byte_enable, busy} !== 4'b0000 ||
            req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_strobes got=%b ack=%b exp=0000 ack=0000",
                     {bus_read, bus_write, bus_byte_enable, busy}, req_ack);
        end
        checks++;
        if (grant_id !== 3'd3 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_grant got=%0d err=%b exp=3 err=0",
                     grant_id, timeout_err);
        end
        reset = 1'b0;
        req_rnw = '0;
        ack_delay = 0;
        resp_en = 1'b1;
        req_valid = 4'b0011;
        wait_ack(20, cyc, bcyc, clash);
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_next got=%b exp=0001", req_ack);
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_fairness();
        test_sparse();
`ifdef VIDEO_BUS_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_bus_arbiter.md
# video_bus_arbiter

Round-robin arbiter and transaction sequencer that shares the single 8-bit FPGA-to-HPS video bus-master external interface among NUM_REQ on-fabric requesters (pixel writers, sprite engines, readback units). It accepts one byte read or write per grant, drives the bus-master address/strobe/data signals until the system interconnect acknowledges, returns read data to the granted requester, then rotates priority. It sits between the drawing engines and the Computer_System bus-master port.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 1024, bus-wait limit in cycles (used only with VIDEO_BUS_ARB_TIMEOUT_EN)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request pending; held until its req_ack
- req_rnw  in  NUM_REQ  1 = read, 0 = write
- req_address  in  NUM_REQ*30  packed, requester i at [30i+29:30i]
- req_write_data  in  NUM_REQ*8  packed, requester i at [8i+7:8i]
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- req_read_data  out  8  read byte, valid while req_ack nonzero
- bus_address  out  30  to bus_master_video_external_interface_address
- bus_byte_enable  out  1  to ..._byte_enable
- bus_read  out  1  to ..._read
- bus_write  out  1  to ..._write
- bus_write_data  out  8  to ..._write_data
- bus_acknowledge  in  1  from ..._acknowledge
- bus_read_data  in  8  from ..._read_data
- busy  out  1  high in BUS and RESP states
- grant_id  out  3  index of current/last granted requester
- timeout_err  out  1  sticky bus-timeout flag

## Operation
- States: IDLE, BUS, RESP.
- IDLE: if any req_valid, select winner = first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap; latch its address, write data, rnw into registers; set last_grant = grant_id = winner; go BUS. Else stay.
- BUS: bus_address/bus_write_data from latches; bus_read = rnw, bus_write = ~rnw, bus_byte_enable = 1. On sampling bus_acknowledge = 1: capture bus_read_data (reads only), go RESP.
- RESP: all bus strobes and byte_enable 0; req_ack[grant_id] = 1; req_read_data = captured byte (writes: last captured value, don't-care). Always go IDLE.
- Requester obligation: deassert or replace req_valid in the cycle after seeing req_ack; RESP guarantees the arbiter does not resample that requester before then.
- req_valid deasserted while granted: ignored; transaction completes and ack still pulses.
- bus_acknowledge outside BUS: ignored.
- All outputs registered. Reset values: req_ack 0, req_read_data 0, bus_address 0, bus_write_data 0, bus_read/bus_write/bus_byte_enable 0, busy 0, grant_id NUM_REQ-1, last_grant NUM_REQ-1 (requester 0 wins first), timeout_err 0, state IDLE.
- Reset mid-transaction: strobes low in the cycle after the reset edge; no req_ack generated for the aborted transfer.

## Timing
- Request sampled in IDLE at edge T: strobes high in cycle T+1.
- bus_acknowledge sampled at edge K: strobes low and req_ack high in cycle K+1; IDLE in K+2; next grant strobes earliest K+3.
- Minimum transaction with zero-wait ack: 3 cycles per transfer; throughput 1 byte / 3 cycles.
- Strobes and address stable for entire BUS duration; never two strobes high simultaneously.
- Starvation bound: a held request is granted within NUM_REQ-1 other transactions.

## Configuration
- VIDEO_BUS_ARB_TIMEOUT_EN defined: 16-bit wait counter cleared on BUS entry, incremented each BUS cycle without ack; on reaching TIMEOUT_CYCLES-1 without ack, go RESP, pulse req_ack, req_read_data = 8'hFF, set timeout_err (sticky until reset). Ack arriving in the same cycle as expiry takes priority (normal completion).
- Not defined: BUS waits indefinitely; timeout_err constant 0; no counter synthesized.

## Test plan
- Single write: req 0 valid, rnw=0, addr 30'h0800_0010, data 8'h3C, ack after 2 cycles -> bus_write high 3 cycles with those values, req_ack = 4'b0001 for one cycle, busy low 1 cycle later.
- Read: req 2 rnw=1, addr 30'h0000_0100, bus_read_data 8'hA5 with ack delay 5 -> req_ack = 4'b0100, req_read_data 8'hA5.
- Fairness: all four req_valid held, two transfers each, zero-wait ack -> grant order 0,1,2,3,0,1,2,3; 3 cycles per transfer.
- Sparse round-robin: after grant to 1, requests from 0 and 3 -> 3 granted before 0.
- Timeout (macro on, TIMEOUT_CYCLES=16): no ack -> req_ack after 16 BUS cycles, read data 8'hFF, timeout_err stays 1 until reset.
- Reset in BUS state: strobes 0 next cycle, no req_ack, next request goes to requester 0 first.
